// File: rtl/iomem_arbiter.sv
// Two-master arbiter in front of a single-outstanding memory port.
// Round-robin on contention, one transaction in flight, timeout completes with an error.
module iomem_arbiter #(
  parameter  int ADDR_W      = 32,
  parameter  int LINE_W      = 128,
  parameter  int TIMEOUT_CYC = 64,
  localparam int BE_W        = LINE_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_valid_i,
  input  logic [ADDR_W-1:0] m0_req_addr_i,
  input  logic [BE_W-1:0]   m0_req_rw_i,
  input  logic [LINE_W-1:0] m0_req_data_i,
  output logic              m0_req_ready_o,
  output logic              m0_res_valid_o,
  output logic [LINE_W-1:0] m0_res_data_o,
  output logic              m0_res_err_o,
  input  logic              m1_req_valid_i,
  input  logic [ADDR_W-1:0] m1_req_addr_i,
  input  logic [BE_W-1:0]   m1_req_rw_i,
  input  logic [LINE_W-1:0] m1_req_data_i,
  output logic              m1_req_ready_o,
  output logic              m1_res_valid_o,
  output logic [LINE_W-1:0] m1_res_data_o,
  output logic              m1_res_err_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [BE_W-1:0]   mem_req_rw_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_res_valid_i,
  input  logic              mem_res_ready_i,
  input  logic [LINE_W-1:0] mem_res_data_i
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   rw_q, rw_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic grant_s;
  logic sel_s;
  logic resp_s;
  logic tmo_s;

  // sel_s = 1 selects m1; only meaningful while grant_s is high
  assign sel_s   = (m0_req_valid_i && m1_req_valid_i) ? rr_q : m1_req_valid_i;
  assign grant_s = (state_q == ST_IDLE) && mem_res_ready_i && (m0_req_valid_i || m1_req_valid_i);
  assign resp_s  = (state_q == ST_BUSY) && mem_res_valid_i;
  assign tmo_s   = (state_q == ST_BUSY) && !mem_res_valid_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rw_q    <= '0;
      data_q  <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    data_d  = data_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          addr_d  = sel_s ? m1_req_addr_i : m0_req_addr_i;
          rw_d    = sel_s ? m1_req_rw_i   : m0_req_rw_i;
          data_d  = sel_s ? m1_req_data_i : m0_req_data_i;
          owner_d = sel_s;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (resp_s || tmo_s) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rr_d    = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, which also silences an aborted BUSY cycle
  always_comb begin
    m0_req_ready_o  = 1'b0;
    m1_req_ready_o  = 1'b0;
    m0_res_valid_o  = 1'b0;
    m0_res_data_o   = '0;
    m0_res_err_o    = 1'b0;
    m1_res_valid_o  = 1'b0;
    m1_res_data_o   = '0;
    m1_res_err_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_rw_o    = '0;
    mem_req_data_o  = '0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          m0_req_ready_o = grant_s && !sel_s;
          m1_req_ready_o = grant_s && sel_s;
        end
        ST_BUSY: begin
          mem_req_valid_o = 1'b1;
          mem_req_addr_o  = addr_q;
          mem_req_rw_o    = rw_q;
          mem_req_data_o  = data_q;
          if (resp_s || tmo_s) begin
            if (owner_q) begin
              m1_res_valid_o = 1'b1;
              m1_res_data_o  = resp_s ? mem_res_data_i : '0;
              m1_res_err_o   = tmo_s;
            end else begin
              m0_res_valid_o = 1'b1;
              m0_res_data_o  = resp_s ? mem_res_data_i : '0;
              m0_res_err_o   = tmo_s;
            end
          end else begin
            mem_req_valid_o = 1'b1;
          end
        end
        ST_DONE: mem_req_valid_o = 1'b0;
        default: mem_req_valid_o = 1'b0;
      endcase
    end else begin
      mem_req_valid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter: inputs change just after the rising edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_iomem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int BE_W   = LINE_W / 8;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_v, m1_v;
  logic [ADDR_W-1:0] m0_a, m1_a;
  logic [BE_W-1:0]   m0_rw, m1_rw;
  logic [LINE_W-1:0] m0_d, m1_d;
  logic              m0_rdy, m1_rdy;
  logic              m0_rv, m1_rv;
  logic [LINE_W-1:0] m0_rd, m1_rd;
  logic              m0_re, m1_re;
  logic              mem_v;
  logic [ADDR_W-1:0] mem_a;
  logic [BE_W-1:0]   mem_rw;
  logic [LINE_W-1:0] mem_d;
  logic              mem_res_v, mem_rdy;
  logic [LINE_W-1:0] mem_res_d;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [LINE_W-1:0] D_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] D_WR = 128'h112233445566778899AABBCCDDEEFF00;
  localparam logic [LINE_W-1:0] D_X1 = 128'h0123456789ABCDEF0011223344556677;
  localparam logic [LINE_W-1:0] D_X2 = 128'hCAFEBABE00000000FFFFFFFF12345678;
  localparam logic [LINE_W-1:0] D_X3 = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [LINE_W-1:0] D_X4 = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
  localparam logic [LINE_W-1:0] D_X6 = 128'h0F0E0D0C0B0A09080706050403020100;

  always #5 clk = ~clk;

  iomem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_valid_i(m0_v), .m0_req_addr_i(m0_a), .m0_req_rw_i(m0_rw), .m0_req_data_i(m0_d),
    .m0_req_ready_o(m0_rdy), .m0_res_valid_o(m0_rv), .m0_res_data_o(m0_rd), .m0_res_err_o(m0_re),
    .m1_req_valid_i(m1_v), .m1_req_addr_i(m1_a), .m1_req_rw_i(m1_rw), .m1_req_data_i(m1_d),
    .m1_req_ready_o(m1_rdy), .m1_res_valid_o(m1_rv), .m1_res_data_o(m1_rd), .m1_res_err_o(m1_re),
    .mem_req_valid_o(mem_v), .mem_req_addr_o(mem_a), .mem_req_rw_o(mem_rw), .mem_req_data_o(mem_d),
    .mem_res_valid_i(mem_res_v), .mem_res_ready_i(mem_rdy), .mem_res_data_i(mem_res_d)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".m0_rdy"}, LINE_W'(m0_rdy), '0);
    chk({tag, ".m1_rdy"}, LINE_W'(m1_rdy), '0);
    chk({tag, ".m0_rv"},  LINE_W'(m0_rv),  '0);
    chk({tag, ".m1_rv"},  LINE_W'(m1_rv),  '0);
    chk({tag, ".m0_re"},  LINE_W'(m0_re),  '0);
    chk({tag, ".m1_re"},  LINE_W'(m1_re),  '0);
    chk({tag, ".m0_rd"},  m0_rd,           '0);
    chk({tag, ".m1_rd"},  m1_rd,           '0);
    chk({tag, ".mem_v"},  LINE_W'(mem_v),  '0);
    chk({tag, ".mem_a"},  LINE_W'(mem_a),  '0);
    chk({tag, ".mem_rw"}, LINE_W'(mem_rw), '0);
    chk({tag, ".mem_d"},  mem_d,           '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_v = 1'b0; m0_a = '0; m0_rw = '0; m0_d = '0;
    m1_v = 1'b0; m1_a = '0; m1_rw = '0; m1_d = '0;
    mem_res_v = 1'b0; mem_res_d = '0; mem_rdy = 1'b1;

    // Reset with a pending request: everything must stay low
    m0_v = 1'b1; m0_a = 32'h100;
    step(); step();
    @(negedge clk); chk_all_zero("reset");
    step();

    // Memory not ready: no grant, no memory request
    rst = 1'b0; mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.m0_rdy", LINE_W'(m0_rdy), '0);
      chk("stall.mem_v",  LINE_W'(mem_v),  '0);
      step();
    end
    mem_rdy = 1'b1;
    @(negedge clk);
    chk("rd.accept_rdy", LINE_W'(m0_rdy), 128'd1);
    chk("rd.accept_m1",  LINE_W'(m1_rdy), '0);
    step();
    m0_v = 1'b0; m0_a = 32'hFFFF_FFFF;

    // 16 BUSY cycles, response on the 16th
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin mem_res_v = 1'b1; mem_res_d = D_A5; end
      @(negedge clk);
      chk("rd.mem_v",  LINE_W'(mem_v),  128'd1);
      chk("rd.mem_a",  LINE_W'(mem_a),  128'h100);
      chk("rd.mem_rw", LINE_W'(mem_rw), '0);
      chk("rd.m0_rv",  LINE_W'(m0_rv),  LINE_W'(i == 16));
      chk("rd.m1_rv",  LINE_W'(m1_rv),  '0);
      step();
    end
    // Stray response held through DONE and the following IDLE
    @(negedge clk);
    chk("rd.done_mem_v", LINE_W'(mem_v), '0);
    chk("rd.done_rv",    LINE_W'(m0_rv), '0);
    chk("rd.done_rd",    m0_rd,          '0);
    step();
    @(negedge clk);
    chk("rd.idle_rv",    LINE_W'(m0_rv), '0);
    chk("rd.idle_mem_v", LINE_W'(mem_v), '0);
    step();
    mem_res_v = 1'b0;

    // Check response data/err on the pulse cycle in a dedicated transaction below
    // Contention after reset: m0 first, then m1
    rst = 1'b1; step(); rst = 1'b0;
    m0_v = 1'b1; m0_a = 32'h200;
    m1_v = 1'b1; m1_a = 32'h300;
    @(negedge clk);
    chk("arb.m0_rdy", LINE_W'(m0_rdy), 128'd1);
    chk("arb.m1_rdy", LINE_W'(m1_rdy), '0);
    step();
    m0_v = 1'b0;
    @(negedge clk);
    chk("arb.busy_addr", LINE_W'(mem_a),  128'h200);
    chk("arb.busy_m1",   LINE_W'(m1_rdy), '0);
    step();
    mem_res_v = 1'b1; mem_res_d = D_X1;
    @(negedge clk);
    chk("arb.m0_rv",  LINE_W'(m0_rv), 128'd1);
    chk("arb.m0_rd",  m0_rd,          D_X1);
    chk("arb.m0_re",  LINE_W'(m0_re), '0);
    chk("arb.m1_rv",  LINE_W'(m1_rv), '0);
    chk("arb.m1_rd",  m1_rd,          '0);
    step();
    mem_res_v = 1'b0;
    @(negedge clk); chk("arb.done_m1_rdy", LINE_W'(m1_rdy), '0);
    step();
    @(negedge clk);
    chk("arb.idle_m1_rdy", LINE_W'(m1_rdy), 128'd1);
    chk("arb.idle_m0_rdy", LINE_W'(m0_rdy), '0);
    step();
    m1_v = 1'b0;
    mem_res_v = 1'b1; mem_res_d = D_X2;
    @(negedge clk);
    chk("arb.m1_addr", LINE_W'(mem_a), 128'h300);
    chk("arb.m1_rv",   LINE_W'(m1_rv), 128'd1);
    chk("arb.m1_data", m1_rd,          D_X2);
    chk("arb.m0_idle", LINE_W'(m0_rv), '0);
    step();
    mem_res_v = 1'b0;
    step();

    // m1 write: fields held for the whole BUSY phase
    m1_v = 1'b1; m1_a = 32'h40; m1_rw = 16'h000F; m1_d = D_WR;
    @(negedge clk); chk("wr.accept", LINE_W'(m1_rdy), 128'd1);
    step();
    m1_v = 1'b0; m1_a = 32'h0000_0FFF; m1_rw = '0; m1_d = '0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin mem_res_v = 1'b1; mem_res_d = D_X3; end
      @(negedge clk);
      chk("wr.mem_rw", LINE_W'(mem_rw), 128'h000F);
      chk("wr.mem_a",  LINE_W'(mem_a),  128'h40);
      chk("wr.mem_d",  mem_d,           D_WR);
      chk("wr.m1_rv",  LINE_W'(m1_rv),  LINE_W'(i == 5));
      chk("wr.m0_rv",  LINE_W'(m0_rv),  '0);
      step();
    end
    mem_res_v = 1'b0;
    @(negedge clk);
    chk("wr.done_rv",    LINE_W'(m1_rv), '0);
    chk("wr.done_mem_v", LINE_W'(mem_v), '0);
    step();

    // Timeout on m0: error pulse on the 64th BUSY cycle
    m0_v = 1'b1; m0_a = 32'h500;
    @(negedge clk); chk("tmo.accept", LINE_W'(m0_rdy), 128'd1);
    step();
    m0_v = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      chk("tmo.mem_v", LINE_W'(mem_v), 128'd1);
      chk("tmo.m0_rv", LINE_W'(m0_rv), LINE_W'(i == TMO));
      chk("tmo.m0_re", LINE_W'(m0_re), LINE_W'(i == TMO));
      chk("tmo.m0_rd", m0_rd,          '0);
      step();
    end
    @(negedge clk);
    chk("tmo.after_mem_v", LINE_W'(mem_v), '0);
    chk("tmo.after_rv",    LINE_W'(m0_rv), '0);
    step();

    // Response arriving on the timeout cycle wins over the error
    m1_v = 1'b1; m1_a = 32'h600;
    @(negedge clk); chk("tie.accept", LINE_W'(m1_rdy), 128'd1);
    step();
    m1_v = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      if (i == TMO) begin mem_res_v = 1'b1; mem_res_d = D_X4; end
      @(negedge clk);
      chk("tie.m1_rv", LINE_W'(m1_rv), LINE_W'(i == TMO));
      chk("tie.m1_re", LINE_W'(m1_re), '0);
      step();
    end
    mem_res_v = 1'b0;
    step();

    // Reset on the 5th BUSY cycle aborts silently
    m0_v = 1'b1; m0_a = 32'h700;
    @(negedge clk); chk("abort.accept", LINE_W'(m0_rdy), 128'd1);
    step();
    m0_v = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); chk("abort.mem_v", LINE_W'(mem_v), 128'd1);
      step();
    end
    rst = 1'b1; mem_res_v = 1'b1; mem_res_d = D_X3;
    @(negedge clk); chk_all_zero("abort.in_rst");
    step();
    rst = 1'b0; mem_res_v = 1'b0;
    @(negedge clk); chk_all_zero("abort.after");
    step();
    m1_v = 1'b1; m1_a = 32'h800;
    @(negedge clk); chk("abort.m1_rdy", LINE_W'(m1_rdy), 128'd1);
    step();
    m1_v = 1'b0;
    mem_res_v = 1'b1; mem_res_d = D_X6;
    @(negedge clk);
    chk("abort.m1_addr", LINE_W'(mem_a), 128'h800);
    chk("abort.m1_rv",   LINE_W'(m1_rv), 128'd1);
    chk("abort.m1_rd",   m1_rd,          D_X6);
    step();
    mem_res_v = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
